// File: rtl/motor_pkg.sv
// motor_pkg
// Shared definitions for the motor speed-select FSM and the PWM generator:
// speed codes, the code-to-duty table, the ramp FSM state encoding and the
// number of PWM steps per period.
package motor_pkg;

  localparam int PWM_STEPS = 100;

  localparam logic [2:0] S_SPEED_0 = 3'd0;
  localparam logic [2:0] S_SPEED_1 = 3'd1;
  localparam logic [2:0] S_SPEED_2 = 3'd2;
  localparam logic [2:0] S_SPEED_3 = 3'd3;
  localparam logic [2:0] S_SPEED_4 = 3'd4;

  localparam logic [6:0] DUTY_0 = 7'd0;
  localparam logic [6:0] DUTY_1 = 7'd25;
  localparam logic [6:0] DUTY_2 = 7'd50;
  localparam logic [6:0] DUTY_3 = 7'd75;
  localparam logic [6:0] DUTY_4 = 7'd100;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_BRAKE     = 2'd3
  } ramp_state_e;

  // Codes 5..7 are not produced by a healthy speed FSM; treat them as a stop
  // request so a corrupted code can never drive the motor.
  function automatic logic [6:0] target_duty(input logic [2:0] code);
    case (code)
      S_SPEED_0: return DUTY_0;
      S_SPEED_1: return DUTY_1;
      S_SPEED_2: return DUTY_2;
      S_SPEED_3: return DUTY_3;
      S_SPEED_4: return DUTY_4;
      default:   return DUTY_0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen
// Prescaler for the PWM counter. Counts 0..PRESCALE-1 and raises tick while
// the count sits at PRESCALE-1, then wraps.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   clear - synchronous restart of the count from 0
//   tick  - high on the last clock of each prescale interval
module pwm_tick_gen #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // With PRESCALE=1 the count is pinned at 0, so tick is permanently high.
  assign tick = (count == LAST);

endmodule

// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen
// Turns the 3-bit speed code into a 100-step PWM drive. The applied duty ramps
// toward the target by RAMP_STEP percent per PWM period (soft start/stop) and
// only changes at period boundaries; the brake input overrides everything and
// forces duty to 0 immediately.
// Ports:
//   i_clk         - system clock
//   i_reset       - asynchronous active-high reset
//   i_speed_state - speed code, 0..4 valid, 5..7 treated as stop
//   i_brake       - level brake request
//   o_pwm         - registered PWM output
//   o_duty        - applied duty in percent (0..100)
//   o_at_target   - applied duty equals target and brake is released
//   o_period_end  - one-clock pulse marking each PWM period boundary
module motor_pwm_gen
  import motor_pkg::*;
#(
  parameter int PRESCALE  = 10,
  parameter int RAMP_STEP = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_speed_state,
  input  logic       i_brake,
  output logic       o_pwm,
  output logic [6:0] o_duty,
  output logic       o_at_target,
  output logic       o_period_end
);

  localparam logic [6:0] CNT_LAST = 7'(PWM_STEPS - 1);
  localparam logic [6:0] STEP7    = 7'(RAMP_STEP);
  localparam logic [7:0] STEP8    = 8'(RAMP_STEP);

  ramp_state_e state;
  ramp_state_e state_next;

  logic [6:0] r_cnt;
  logic [6:0] r_duty;
  logic [6:0] duty_next;
  logic [6:0] target;
  logic [7:0] up_sum;
  logic [7:0] down_limit;
  logic [6:0] ramp_up_val;
  logic [6:0] ramp_down_val;
  logic       tick;
  logic       period_end;
  logic       brake_entry;

  assign target      = target_duty(i_speed_state);
  assign period_end  = tick && (r_cnt == CNT_LAST);
  assign brake_entry = i_brake && (state != ST_BRAKE);

  // Brake entry restarts the period so the soft restart begins on a clean
  // period boundary.
  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (i_clk),
    .rst  (i_reset),
    .clear(brake_entry),
    .tick (tick)
  );

  // PWM position within the period, advancing once per prescaler tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (brake_entry) begin
      r_cnt <= '0;
    end else if (tick) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 7'd1;
      end
    end
  end

  // Ramp arithmetic is done in 8 bits so duty+step (up to 200) cannot wrap
  // before the saturation compare. Both directions saturate at the target.
  always_comb begin
    up_sum        = {1'b0, r_duty} + STEP8;
    down_limit    = {1'b0, target} + STEP8;
    ramp_up_val   = (up_sum >= {1'b0, target}) ? target : up_sum[6:0];
    ramp_down_val = ({1'b0, r_duty} > down_limit) ? (r_duty - STEP7) : target;
  end

  // Ramp FSM next state and next duty. Direction is re-evaluated every clock,
  // but the duty itself only moves at a period end, except on brake.
  always_comb begin
    state_next = state;
    duty_next  = r_duty;
    if (i_brake) begin
      state_next = ST_BRAKE;
      duty_next  = 7'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (target > r_duty) begin
            state_next = ST_RAMP_UP;
          end else if (target < r_duty) begin
            state_next = ST_RAMP_DOWN;
          end
        end
        ST_RAMP_UP: begin
          if (target < r_duty) begin
            state_next = ST_RAMP_DOWN;
          end else if (target == r_duty) begin
            state_next = ST_IDLE;
          end else if (period_end) begin
            duty_next = ramp_up_val;
            if (ramp_up_val == target) begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (target > r_duty) begin
            state_next = ST_RAMP_UP;
          end else if (target == r_duty) begin
            state_next = ST_IDLE;
          end else if (period_end) begin
            duty_next = ramp_down_val;
            if (ramp_down_val == target) begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_BRAKE: begin
          duty_next  = 7'd0;
          state_next = (target > 7'd0) ? ST_RAMP_UP : ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
          duty_next  = 7'd0;
        end
      endcase
    end
  end

  // State, duty and the registered outputs. o_at_target is taken from the
  // next state so it changes on the same edge as the state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      r_duty       <= '0;
      o_at_target  <= 1'b1;
      o_pwm        <= 1'b0;
      o_period_end <= 1'b0;
    end else begin
      state        <= state_next;
      r_duty       <= duty_next;
      o_at_target  <= (state_next == ST_IDLE);
      o_pwm        <= (r_cnt < r_duty) && (state != ST_BRAKE);
      o_period_end <= period_end;
    end
  end

  assign o_duty = r_duty;

endmodule
